// File: rtl/button_conditioner_if.sv
// button_conditioner_if: raw button pins in, conditioned button levels and event pulses out
interface button_conditioner_if #(
    parameter int NUM_BUTTONS = 2
);
    logic [NUM_BUTTONS-1:0] button_n;
    logic [NUM_BUTTONS-1:0] button_level;
    logic [NUM_BUTTONS-1:0] button_press;
    logic [NUM_BUTTONS-1:0] button_release;
    logic [NUM_BUTTONS-1:0] button_hold;

    modport master (
        output button_n,
        input  button_level,
        input  button_press,
        input  button_release,
        input  button_hold
    );

    modport slave (
        input  button_n,
        output button_level,
        output button_press,
        output button_release,
        output button_hold
    );
endinterface

// File: rtl/button_conditioner.sv
// button_conditioner: synchronizes, debounces and edge/hold-detects active-low push buttons
module button_conditioner #(
    parameter int NUM_BUTTONS     = 2,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int HOLD_CYCLES     = 50000000,
    parameter int COUNT_WIDTH     = 26
) (
    input  logic                clock,
    input  logic                reset_n,
    button_conditioner_if.slave bus
);
    typedef enum logic [1:0] {
        RELEASED,
        PRESS_PENDING,
        PRESSED,
        RELEASE_PENDING
    } state_t;

    localparam logic [COUNT_WIDTH-1:0] DEB_MAX  = COUNT_WIDTH'(DEBOUNCE_CYCLES);
    localparam logic [COUNT_WIDTH-1:0] HOLD_MAX = COUNT_WIDTH'(HOLD_CYCLES);
    localparam logic [COUNT_WIDTH-1:0] ONE      = COUNT_WIDTH'(1);

    logic [NUM_BUTTONS-1:0] sync1, sync2, raw;
    state_t                 state      [NUM_BUTTONS];
    state_t                 state_next [NUM_BUTTONS];
    logic [COUNT_WIDTH-1:0] dcnt       [NUM_BUTTONS];
    logic [COUNT_WIDTH-1:0] dcnt_next  [NUM_BUTTONS];
    logic [COUNT_WIDTH-1:0] hcnt       [NUM_BUTTONS];
    logic [COUNT_WIDTH-1:0] hcnt_next  [NUM_BUTTONS];
    logic [NUM_BUTTONS-1:0] level, press, rel, hold;
    logic [NUM_BUTTONS-1:0] level_next, press_next, rel_next, hold_next;

    assign raw                = ~sync2;
    assign bus.button_level   = level;
    assign bus.button_press   = press;
    assign bus.button_release = rel;
    assign bus.button_hold    = hold;

    // Two-flop synchronizer; idles high so a reset looks like "not pressed"
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= '1;
            sync2 <= '1;
        end else begin
            sync1 <= bus.button_n;
            sync2 <= sync1;
        end
    end

    // Per-channel state, counters and registered outputs
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= '{default: RELEASED};
            dcnt  <= '{default: '0};
            hcnt  <= '{default: '0};
            level <= '0;
            press <= '0;
            rel   <= '0;
            hold  <= '0;
        end else begin
            state <= state_next;
            dcnt  <= dcnt_next;
            hcnt  <= hcnt_next;
            level <= level_next;
            press <= press_next;
            rel   <= rel_next;
            hold  <= hold_next;
        end
    end

    // Debounce FSM per channel; hold counter runs while the press is accepted
    always_comb begin
        state_next = state;
        dcnt_next  = dcnt;
        hcnt_next  = hcnt;
        level_next = level;
        press_next = '0;
        rel_next   = '0;
        hold_next  = '0;
        for (int i = 0; i < NUM_BUTTONS; i++) begin
            if (state[i] == PRESSED || state[i] == RELEASE_PENDING) begin
                hcnt_next[i] = (hcnt[i] == HOLD_MAX) ? HOLD_MAX : hcnt[i] + ONE;
                hold_next[i] = (hcnt[i] == HOLD_MAX - ONE);
            end
            case (state[i])
                RELEASED: begin
                    state_next[i] = raw[i] ? PRESS_PENDING : RELEASED;
                    dcnt_next[i]  = raw[i] ? ONE : '0;
                end
                PRESS_PENDING: begin
                    if (!raw[i]) begin
                        state_next[i] = RELEASED;
                        dcnt_next[i]  = '0;
                    end else if (dcnt[i] == DEB_MAX) begin
                        state_next[i] = PRESSED;
                        level_next[i] = 1'b1;
                        press_next[i] = 1'b1;
                        dcnt_next[i]  = '0;
                        hcnt_next[i]  = '0;
                    end else begin
                        dcnt_next[i] = dcnt[i] + ONE;
                    end
                end
                PRESSED: begin
                    if (!raw[i]) begin
                        state_next[i] = RELEASE_PENDING;
                        dcnt_next[i]  = ONE;
                    end
                end
                RELEASE_PENDING: begin
                    if (raw[i]) begin
                        state_next[i] = PRESSED;
                        dcnt_next[i]  = '0;
                    end else if (dcnt[i] == DEB_MAX) begin
                        state_next[i] = RELEASED;
                        level_next[i] = 1'b0;
                        rel_next[i]   = 1'b1;
                        hold_next[i]  = 1'b0;
                        dcnt_next[i]  = '0;
                        hcnt_next[i]  = '0;
                    end else begin
                        dcnt_next[i] = dcnt[i] + ONE;
                    end
                end
            endcase
        end
    end
endmodule
